// File: rtl/ring_buffer_pkg.sv
// Shared types and helpers for the ring-buffer stream controller.
package ring_buffer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ring_storage.sv
// Ring storage: data and per-slot valid bits, one write port, async read.
module ring_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       vld_wr_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       vld_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;

  // A bubble write clears the valid bit but leaves the stale data in place.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld <= '0;
    end else if (we_i) begin
      vld[addr_i] <= vld_wr_i;
      if (vld_wr_i) mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];
  assign vld_o   = vld[addr_i];

endmodule

// File: rtl/ring_buffer_stream_ctrl.sv
// Valid/ready delay-line controller over a single-pointer ring, with bubble-draining flush.
module ring_buffer_stream_ctrl
  import ring_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         flush_i,
  output logic                         flush_busy_o,
  output logic                         flush_done_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic            flush_done_q;
  logic            slot_vld;
  logic            run_ready;
  logic            in_fire, out_fire;
  logic            adv, vld_wr;

  ring_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_storage (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (adv),
    .addr_i   (ptr),
    .wdata_i  (in_data_i),
    .vld_wr_i (vld_wr),
    .rdata_o  (out_data_o),
    .vld_o    (slot_vld)
  );

  assign out_valid_o  = slot_vld;
  assign run_ready    = !slot_vld | out_ready_i;
  assign out_fire     = slot_vld & out_ready_i;
  assign in_fire      = in_valid_i & in_ready_o;
  assign count_o      = count;
  assign flush_done_o = flush_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_done_q <= (state == FLUSH) && (count == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:   if (flush_i) state_nxt = FLUSH;
      FLUSH: if (count == '0) state_nxt = RUN;
    endcase
  end

  // FLUSH only ever writes bubbles; empty slots are stepped over without a consumer.
  always_comb begin
    in_ready_o   = 1'b0;
    adv          = 1'b0;
    vld_wr       = 1'b0;
    flush_busy_o = 1'b0;
    unique case (state)
      RUN: begin
        in_ready_o = run_ready;
        adv        = (in_valid_i & run_ready) | out_fire;
        vld_wr     = in_valid_i & run_ready;
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        adv          = (count != '0) & run_ready;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      if (adv) ptr <= PW'(ptr_next(32'(ptr), $unsigned(DEPTH)));
      if (in_fire && !out_fire)      count <= count + CW'(1);
      else if (!in_fire && out_fire) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ring_buffer_stream_ctrl.sv
// Directed bench for ring_buffer_stream_ctrl with DEPTH=4, WIDTH=8.
module tb_ring_buffer_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       flush, flush_busy, flush_done;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  ring_buffer_stream_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .flush_i      (flush),
    .flush_busy_o (flush_busy),
    .flush_done_o (flush_done),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; in_data = 0; flush = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
      failures++; $display("FAIL reset_flush busy=%b done=%b exp=0,0", flush_busy, flush_done); end
  endtask

  task automatic fill(input logic [7:0] d0, d1, d2, d3, input bit check);
    logic [7:0] vals [4];
    vals = '{d0, d1, d2, d3};
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      tick();
      if (check) begin
        checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      end
    end
    in_valid = 0;
  endtask

  task automatic test_fill();
    fill(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++; $display("FAIL fill_head valid=%b data=%h exp=1,11", out_valid, out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_full_stall();
    in_valid = 1; in_data = 8'h55; out_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (out_data !== 8'h11 || count !== 3'd4) begin
      failures++; $display("FAIL stall_hold data=%h count=%0d exp=11,4", out_data, count); end
  endtask

  task automatic test_full_passthru();
    in_valid = 1; in_data = 8'h55; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL passthru_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0; out_ready = 0;
    checks++; if (out_data !== 8'h22 || count !== 3'd4 || out_valid !== 1'b1) begin
      failures++; $display("FAIL passthru_next data=%h count=%0d valid=%b exp=22,4,1", out_data, count, out_valid); end
  endtask

  task automatic test_flush_drain();
    logic [7:0] exp_d [3];
    exp_d = '{8'h33, 8'h44, 8'h55};
    out_ready = 1; flush = 1;
    checks++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_first data=%h valid=%b exp=22,1", out_data, out_valid); end
    tick();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      #1;
      checks++; if (flush_busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL flush_busy[%0d] busy=%b in_ready=%b exp=1,0", i, flush_busy, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        failures++; $display("FAIL flush_out[%0d] valid=%b data=%h exp=1,%h", i, out_valid, out_data, exp_d[i]); end
      tick();
    end
    in_valid = 0;
    checks++; if (count !== 3'd0 || flush_busy !== 1'b1 || flush_done !== 1'b0) begin
      failures++; $display("FAIL flush_empty count=%0d busy=%b done=%b exp=0,1,0", count, flush_busy, flush_done); end
    tick();
    checks++; if (flush_done !== 1'b1 || flush_busy !== 1'b0) begin
      failures++; $display("FAIL flush_done_pulse done=%b busy=%b exp=1,0", flush_done, flush_busy); end
    tick();
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_done_single got=%b exp=0", flush_done); end
    out_ready = 0;
  endtask

  task automatic test_bubble_delay();
    do_reset();
    fill(8'hA1, 8'h00, 8'h00, 8'h00, 1'b0);
    // fill() already advanced; replay the visibility check on a fresh ring step by step
    do_reset();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = (i == 0) ? 8'hA1 : 8'h00;
      tick();
      if (i < 3) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL delay_early[%0d] valid=%b exp=0", i, out_valid); end
      end
    end
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
      failures++; $display("FAIL delay_emerge valid=%b data=%h exp=1,a1", out_valid, out_data); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd3 || out_valid !== 1'b1 || out_data !== 8'h00) begin
      failures++; $display("FAIL pop_bubble count=%0d valid=%b data=%h exp=3,1,00", count, out_valid, out_data); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush = 1;
    tick();
    flush = 0;
    checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin
      failures++; $display("FAIL empty_flush_busy busy=%b done=%b exp=1,0", flush_busy, flush_done); end
    tick();
    checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b1) begin
      failures++; $display("FAIL empty_flush_done busy=%b done=%b exp=0,1", flush_busy, flush_done); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    bit saw_done;
    do_reset();
    fill(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    flush = 1; out_ready = 0;
    tick();
    flush = 0; out_ready = 1;
    tick(); tick();
    checks++; if (flush_busy !== 1'b1 || count !== 3'd2 || out_data !== 8'h33) begin
      failures++; $display("FAIL midflush_pre busy=%b count=%0d data=%h exp=1,2,33", flush_busy, count, out_data); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || flush_busy !== 1'b0) begin
      failures++; $display("FAIL midflush_reset valid=%b count=%0d busy=%b exp=0,0,0", out_valid, count, flush_busy); end
    saw_done = 0;
    for (int i = 0; i < 2; i++) begin tick(); if (flush_done) saw_done = 1; end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (flush_done) saw_done = 1; end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midflush_no_done got=%b exp=0", saw_done); end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_stall();
    test_full_passthru();
    test_flush_drain();
    test_bubble_delay();
    test_flush_empty();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
